aes_encoder: RTL and testbench



---
 rtl/aes_encoder.sv | 197 +++++++++++++++++++
 tb/tb_aes_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_encoder.sv
// aes_encoder: fully pipelined AES-128 encrypt core, one round per stage.
// A new plaintext/key pair enters every cycle; ciphertext appears 10 cycles later.
// Round keys travel down the pipe beside the data and are expanded on the fly.
// Build option: AES_ENC_SBOX_LUT_EN selects a constant S-box table; otherwise
// the S-box is computed as GF(2^8) inverse plus affine transform.
module aes_encoder #(
    parameter int unsigned KEY_SIZE = 128
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [127:0]        in,
    input  logic [KEY_SIZE-1:0] key,
    output logic [127:0]        out,
    output logic                valid
);
    localparam int unsigned NUM_ROUNDS = 10;

    if (KEY_SIZE != 128) begin : g_key_size_check
        $error("aes_encoder: KEY_SIZE must be 128");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef AES_ENC_SBOX_LUT_EN
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = '0;
        endcase
        return s;
    endfunction
`else
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 via an addition chain; 0 naturally maps to 0.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] v;
        t = gf_mul(gf_mul(a, a), a);          // a^3
        t = gf_mul(gf_mul(t, t), a);          // a^7
        t = gf_mul(gf_mul(t, t), a);          // a^15
        t = gf_mul(gf_mul(t, t), a);          // a^31
        t = gf_mul(gf_mul(t, t), a);          // a^63
        t = gf_mul(gf_mul(t, t), a);          // a^127
        v = gf_mul(t, t);                     // a^254
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction
`endif

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned b = 0; b < 16; b++) r[8*b +: 8] = sbox(s[8*b +: 8]);
        return r;
    endfunction

    // Byte i sits at bits [127-8i -: 8]; row r of column c is byte r+4c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned row = 0; row < 4; row++)
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) r[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
        return r;
    endfunction

    function automatic logic [7:0] rcon(input int unsigned round);
        case (round)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = rk;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0]          state_q [1:NUM_ROUNDS];
    logic [127:0]          state_d [1:NUM_ROUNDS];
    logic [127:0]          rk_q    [1:NUM_ROUNDS-1];
    logic [127:0]          rk_d    [1:NUM_ROUNDS-1];
    logic [NUM_ROUNDS-1:0] valid_sr;

    // The initial AddRoundKey is folded into stage 1's input, so stage j
    // always ends with AddRoundKey(rk_j); the last stage skips MixColumns.
    for (genvar j = 1; j <= NUM_ROUNDS; j++) begin : g_round
        logic [127:0] src_state;
        logic [127:0] src_rk;
        logic [127:0] rk_next;
        logic [127:0] shifted;

        if (j == 1) begin : g_first
            assign src_state = in ^ key;
            assign src_rk    = key;
        end else begin : g_rest
            assign src_state = state_q[j-1];
            assign src_rk    = rk_q[j-1];
        end

        assign rk_next = expand_key(src_rk, rcon(j));
        assign shifted = shift_rows(sub_bytes(src_state));

        if (j == NUM_ROUNDS) begin : g_final
            assign state_d[j] = shifted ^ rk_next;
        end else begin : g_mid
            assign state_d[j] = mix_columns(shifted) ^ rk_next;
            assign rk_d[j]    = rk_next;
        end
    end

    // Pipeline stage registers (state and round key) plus the valid shifter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 1; j <= NUM_ROUNDS; j++) state_q[j] <= '0;
            for (int unsigned j = 1; j < NUM_ROUNDS; j++) rk_q[j] <= '0;
            valid_sr <= '0;
        end else begin
            for (int unsigned j = 1; j <= NUM_ROUNDS; j++) state_q[j] <= state_d[j];
            for (int unsigned j = 1; j < NUM_ROUNDS; j++) rk_q[j] <= rk_d[j];
            valid_sr <= {valid_sr[NUM_ROUNDS-2:0], 1'b1};
        end
    end

    assign out   = state_q[NUM_ROUNDS];
    assign valid = valid_sr[NUM_ROUNDS-1];

endmodule

// File: tb/tb_aes_encoder.sv
// tb_aes_encoder: directed-vector bench for aes_encoder with a byte-level
// reference model used for the plaintext avalanche sweep.
module tb_aes_encoder;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    logic         clock;
    logic         reset;
    logic [127:0] in;
    logic [127:0] key;
    logic [127:0] out;
    logic         valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_encoder #(.KEY_SIZE(128)) dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .key   (key),
        .out   (out),
        .valid (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_differs(input string name, input logic [127:0] got, input logic [127:0] other);
        total_cnt++;
        if (got !== other) pass_cnt++;
        else $display("FAIL %s: got %h which must differ from %h", name, got, other);
    endtask

    // S-box from log/antilog walk: p steps by *3, q tracks p's inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input int n);
        return (n == 1) ? a : (n == 2) ? xt(a) : (xt(a) ^ a);
    endfunction

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  acc;
        logic [127:0] res;
        int          coef [4];
        coef = '{2, 3, 1, 1};
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8] ^ w[b/4][31 - 8*(b%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r < 10) begin
                for (int b = 0; b < 16; b++) t[b] = s[b];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int kk = 0; kk < 4; kk++) acc = acc ^ gmul(t[4*c + kk], coef[(kk - row + 4) % 4]);
                        s[row + 4*c] = acc;
                    end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31 - 8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
        return res;
    endfunction

    // Release reset with vector B held on the inputs; valid must stay low
    // through nine edges, rise on the tenth, and out must carry B's result.
    task automatic release_and_check(input string tag);
        in  = B_PT;
        key = B_KEY;
        @(negedge clock);
        reset = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s_valid_edge%0d", tag, e), {127'd0, valid}, (e == 9) ? 128'd1 : 128'd0);
        end
        check({tag, "_first_out"}, out, B_CT);
    endtask

    vec_t         tab [6];
    logic [127:0] av_exp [128];

    initial begin
        build_sbox();
        tab[0] = '{B_PT, B_KEY, B_CT};
        tab[1] = '{C_PT, C_KEY, C_CT};
        tab[2] = '{128'd0, 128'd0, Z_CT};
        tab[3] = '{C_PT, C_KEY, C_CT};
        tab[4] = '{B_PT, B_KEY, B_CT};
        tab[5] = '{128'd0, 128'd0, Z_CT};
        for (int i = 0; i < 128; i++) av_exp[i] = ref_aes(B_PT ^ (128'd1 << i), B_KEY);

        in    = '0;
        key   = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_out", out, 128'd0);
        check("reset_valid", {127'd0, valid}, 128'd0);
        @(posedge clock);
        #1;
        check("reset_hold_valid", {127'd0, valid}, 128'd0);

        release_and_check("rel1");

        // Back-to-back table vectors with a different key every cycle.
        for (int t = 0; t < 6 + 9; t++) begin
            @(negedge clock);
            if (t < 6) begin
                in  = tab[t].pt;
                key = tab[t].key;
            end else begin
                in  = {$urandom(), $urandom(), $urandom(), $urandom()};
                key = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(posedge clock);
            #1;
            if (t >= 9) begin
                check($sformatf("vec%0d_out", t - 9), out, tab[t-9].ct);
                check($sformatf("vec%0d_valid", t - 9), {127'd0, valid}, 128'd1);
            end
        end

        // Single-bit plaintext flips of vector B, streamed one per cycle.
        for (int t = 0; t < 128 + 9; t++) begin
            @(negedge clock);
            key = B_KEY;
            if (t < 128) in = B_PT ^ (128'd1 << t);
            @(posedge clock);
            #1;
            if (t >= 9) begin
                check($sformatf("aval%0d_out", t - 9), out, av_exp[t-9]);
                check_differs($sformatf("aval%0d_diff", t - 9), out, B_CT);
            end
        end

        // Mid-stream reset pulse clears outputs without waiting for a clock.
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("midrst_out", out, 128'd0);
        check("midrst_valid", {127'd0, valid}, 128'd0);
        @(posedge clock);
        #1;
        check("midrst_hold_valid", {127'd0, valid}, 128'd0);

        release_and_check("rel2");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
